// File: rtl/kinase_valve_sequencer.sv
// Pneumatic valve sequencer for the kinase_activity_2 chip: static valve
// states, 3-phase peristaltic pumping on p1..p3, timed waits and settling.
module kinase_valve_sequencer #(
    parameter int STEP_TICKS   = 1000,
    parameter int WAIT_TICKS   = 1000,
    parameter int SETTLE_TICKS = 500,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [21:0]      cmd_arg,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [12:0]      c,
    output logic [3:0]       s,
    output logic [4:0]       p,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err
);

    localparam int MAX_SW = (STEP_TICKS > WAIT_TICKS) ? STEP_TICKS : WAIT_TICKS;
    localparam int MAX_T  = (MAX_SW > SETTLE_TICKS) ? MAX_SW : SETTLE_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUMP,
        ST_WAIT
    } state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    tick, tick_nx;
    logic [CNT_W-1:0] units, units_nx;
    logic [2:0]       phase, phase_nx;
    logic [2:0]       idx, idx_nx, idx_adv, idx_start;
    logic             dir, dir_nx;
    logic [12:0]      c_nx;
    logic [3:0]       s_nx;
    logic [4:0]       p_nx, p_hold, p_hold_nx;
    logic             done_nx, aborted_nx, err_nx;

    function automatic logic [2:0] pattern(input logic [2:0] i);
        case (i)
            3'd0:    pattern = 3'b001;
            3'd1:    pattern = 3'b011;
            3'd2:    pattern = 3'b010;
            3'd3:    pattern = 3'b110;
            3'd4:    pattern = 3'b100;
            default: pattern = 3'b101;
        endcase
    endfunction

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = !cmd_ready;

    // Phase index walks the 6-entry table modulo 6 in either direction
    always_comb begin
        if (dir) idx_adv = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
        else     idx_adv = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        idx_start = cmd_arg[0] ? 3'd5 : 3'd0;
    end

    always_comb begin
        state_nx   = state;
        tick_nx    = tick;
        units_nx   = units;
        phase_nx   = phase;
        idx_nx     = idx;
        dir_nx     = dir;
        c_nx       = c;
        s_nx       = s;
        p_nx       = p;
        p_hold_nx  = p_hold;
        done_nx    = 1'b0;
        aborted_nx = 1'b0;
        err_nx     = err;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        2'd0: begin
                            c_nx      = cmd_arg[12:0];
                            s_nx      = cmd_arg[16:13];
                            p_nx      = cmd_arg[21:17];
                            p_hold_nx = cmd_arg[21:17];
                            tick_nx   = TW'(SETTLE_TICKS - 1);
                            state_nx  = ST_SETTLE;
                        end
                        2'd1: begin
                            // A zero-count pump behaves as a one-cycle wait
                            if (cmd_count == '0) begin
                                tick_nx  = '0;
                                units_nx = '0;
                                state_nx = ST_WAIT;
                            end else begin
                                dir_nx    = cmd_arg[0];
                                idx_nx    = idx_start;
                                p_nx[2:0] = pattern(idx_start);
                                tick_nx   = TW'(STEP_TICKS - 1);
                                units_nx  = cmd_count - 1'b1;
                                phase_nx  = 3'd0;
                                state_nx  = ST_PUMP;
                            end
                        end
                        2'd2: begin
                            if (cmd_count == '0) begin
                                tick_nx  = '0;
                                units_nx = '0;
                            end else begin
                                tick_nx  = TW'(WAIT_TICKS - 1);
                                units_nx = cmd_count - 1'b1;
                            end
                            state_nx = ST_WAIT;
                        end
                        default: err_nx = 1'b1;
                    endcase
                end
            end
            ST_SETTLE: begin
                if (tick == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    tick_nx = tick - 1'b1;
                end
            end
            ST_PUMP: begin
                if (tick != '0) begin
                    tick_nx = tick - 1'b1;
                end else begin
                    tick_nx   = TW'(STEP_TICKS - 1);
                    idx_nx    = idx_adv;
                    p_nx[2:0] = pattern(idx_adv);
                    if (phase == 3'd5) begin
                        phase_nx = 3'd0;
                        if (units == '0) begin
                            state_nx  = ST_IDLE;
                            done_nx   = 1'b1;
                            p_nx[2:0] = p_hold[2:0];
                        end else begin
                            units_nx = units - 1'b1;
                        end
                    end else begin
                        phase_nx = phase + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (tick != '0) begin
                    tick_nx = tick - 1'b1;
                end else if (units == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    units_nx = units - 1'b1;
                    tick_nx  = TW'(WAIT_TICKS - 1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // Abort wins over a completion landing in the same cycle
        if (abort && state != ST_IDLE) begin
            state_nx   = ST_IDLE;
            p_nx[2:0]  = p_hold[2:0];
            done_nx    = 1'b0;
            aborted_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            units   <= '0;
            phase   <= 3'd0;
            idx     <= 3'd0;
            dir     <= 1'b0;
            c       <= '0;
            s       <= '0;
            p       <= '0;
            p_hold  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            units   <= units_nx;
            phase   <= phase_nx;
            idx     <= idx_nx;
            dir     <= dir_nx;
            c       <= c_nx;
            s       <= s_nx;
            p       <= p_nx;
            p_hold  <= p_hold_nx;
            done    <= done_nx;
            aborted <= aborted_nx;
            err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Scoreboard bench for kinase_valve_sequencer: stimulus queues per-cycle
// expected outputs, a monitor pops one entry per busy/done/aborted cycle.
module tb_kinase_valve_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [21:0]      cmd_arg;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic [12:0]      c;
    logic [3:0]       s;
    logic [4:0]       p;
    logic             busy, done, aborted, err;

    kinase_valve_sequencer #(
        .STEP_TICKS(2), .WAIT_TICKS(3), .SETTLE_TICKS(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_count(cmd_count),
        .abort(abort), .c(c), .s(s), .p(p), .busy(busy), .done(done),
        .aborted(aborted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] c;
        logic [3:0]  s;
        logic [4:0]  p;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    logic [12:0] ec = '0;
    logic [3:0]  es = '0;
    logic [4:0]  ep = '0;
    logic [4:0]  eh = '0;
    logic        eerr = 1'b0;
    logic [2:0]  pt [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    always @(negedge clk) begin
        if (mon_en && !rst && (busy || done || aborted)) begin
            exp_t a, e;
            a = '{c: c, s: s, p: p, busy: busy, done: done,
                  aborted: aborted, err: err};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got %h expected none", a);
            end else begin
                e = q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_out t=%0t got %h expected %h", $time, a, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic a);
        exp_t e;
        e = '{c: ec, s: es, p: ep, busy: b, done: d, aborted: a, err: eerr};
        q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [21:0] arg, input logic [CNT_W-1:0] n);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_count = n;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic do_set(input logic [21:0] arg);
        ec = arg[12:0];
        es = arg[16:13];
        ep = arg[21:17];
        eh = arg[21:17];
        repeat (4) push(1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0);
        issue(2'd0, arg, '0);
    endtask

    task automatic do_pump(input logic dir, input int n);
        if (n == 0) begin
            push(1'b1, 1'b0, 1'b0);
        end else begin
            for (int k = 0; k < n; k++) begin
                for (int ph = 0; ph < 6; ph++) begin
                    ep[2:0] = pt[dir ? 5 - ph : ph];
                    repeat (2) push(1'b1, 1'b0, 1'b0);
                end
            end
            ep[2:0] = eh[2:0];
        end
        push(1'b0, 1'b1, 1'b0);
        issue(2'd1, {21'd0, dir}, CNT_W'(n));
    endtask

    task automatic do_wait(input int n);
        repeat ((n == 0) ? 1 : 3 * n) push(1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0);
        issue(2'd2, '0, CNT_W'(n));
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_arg = '0;
        cmd_count = '0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_c", c, 0);
        chk("reset_s", s, 0);
        chk("reset_p", p, 0);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_flags", {busy, done, aborted, err}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_set({5'b10000, 4'b0101, 13'h1ABC});
        do_pump(1'b0, 1);
        do_pump(1'b1, 2);
        do_wait(3);
        do_wait(0);

        // pump fwd 5, abort raised during busy cycle 7 (pattern 110)
        for (int cy = 1; cy <= 7; cy++) begin
            ep[2:0] = pt[(cy - 1) / 2];
            push(1'b1, 1'b0, 1'b0);
        end
        ep[2:0] = eh[2:0];
        push(1'b0, 1'b0, 1'b1);
        issue(2'd1, 22'd0, 16'd5);
        repeat (6) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        drain();

        eerr = 1'b1;
        issue(2'd3, 22'h3FFFFF, 16'd7);
        @(negedge clk);
        chk("reserved_err", err, 1);
        chk("reserved_ready", cmd_ready, 1);
        chk("reserved_no_done", done, 0);

        do_set({5'b01101, 4'b1010, 13'h0123});
        do_pump(1'b0, 0);
        do_pump(1'b0, 1);
        drain();
        @(posedge clk);
        mon_en = 1'b0;

        // reset in the middle of a reverse pump
        issue(2'd1, 22'd1, 16'd5);
        repeat (3) @(negedge clk);
        chk("midpump_p", p, {eh[4:3], 3'b100});
        chk("midpump_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_c", c, 0);
        chk("rst_mid_s", s, 0);
        chk("rst_mid_p", p, 0);
        chk("rst_mid_flags", {busy, done, aborted, err}, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kinase_valve_sequencer.md
Name: kinase_valve_sequencer

Overview:
- Off-chip pneumatic controller for the kinase_activity_2 chip. It drives the chip's 13 control valves (c1..c13), 4 sieve valves (s1..s4) and 5 pump valves (p1..p5) through solenoid drivers.
- A host issues commands over a valid/ready port. The block applies static valve states, runs p1..p3 as a 3-phase peristaltic pump, and times waits and valve-settle intervals.

Parameters:
- STEP_TICKS, 1000: clocks per peristaltic phase step (≥1).
- WAIT_TICKS, 1000: clocks per WAIT count unit (≥1).
- SETTLE_TICKS, 500: clocks held busy after a SET (≥1).
- CNT_W, 16: width of cmd_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  0=SET, 1=PUMP, 2=WAIT, 3=reserved
- cmd_arg  in  22  SET: [12:0]→c, [16:13]→s, [21:17]→p; PUMP: [0]=direction (0 fwd, 1 rev)
- cmd_count  in  CNT_W  PUMP: pump cycles; WAIT: units
- abort  in  1  synchronous abort of the running command
- c  out  13  control valves, 1=pressurised/closed
- s  out  4  sieve valves
- p  out  5  pump valves
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- err  out  1  sticky reserved-opcode flag

Behaviour:
- Reset (async): c=0, s=0, p=0, static register p_hold=0, state IDLE, cmd_ready=1, busy=0, done=0, aborted=0, err=0.
- States: IDLE, SETTLE, PUMP, WAIT.
- cmd_ready = (state==IDLE). busy = !cmd_ready.
- A command is accepted on the clock edge where cmd_valid && cmd_ready.
- SET:
  - c, s, p and p_hold take their cmd_arg fields on the accept edge.
  - The block goes to SETTLE for SETTLE_TICKS cycles, then returns to IDLE.
- PUMP:
  - p[4:3] hold their value. p[2:0] = {p3,p2,p1} steps through the table 001, 011, 010, 110, 100, 101.
  - Forward starts at index 0 and increments. Reverse starts at index 5 and decrements. The index wraps modulo 6.
  - The first pattern appears on the accept edge. Each pattern is held STEP_TICKS cycles.
  - Total duration is cmd_count*6*STEP_TICKS cycles. On the exit edge p[2:0] is restored to p_hold[2:0].
- WAIT: all outputs hold for cmd_count*WAIT_TICKS cycles.
- cmd_count==0 (PUMP or WAIT):
  - The block spends exactly 1 busy cycle, then IDLE with done.
  - PUMP with count 0 leaves p unchanged.
- done: high for exactly the first IDLE cycle after SETTLE, PUMP or WAIT completes. cmd_ready is already 1 in that cycle, so a back-to-back command may be accepted then.
- Reserved op 3: accepted and discarded, err set (sticky until rst), no done pulse, state stays IDLE.
- Counters:
  - Step/tick counter width is clog2(max(STEP_TICKS, WAIT_TICKS, SETTLE_TICKS)+1).
  - Unit counter is CNT_W wide and counts down to 0, with no wrap past 0.
  - cmd_count=2^CNT_W−1 must complete without overflow.
- abort:
  - When sampled high in SETTLE, PUMP or WAIT, the next edge goes to IDLE.
  - p[2:0] is restored to p_hold[2:0] (SET values remain applied). aborted pulses for 1 cycle; done does not pulse.
  - abort in IDLE is ignored.
  - abort has priority over completion in the same cycle.
- cmd_valid while busy is ignored. The host must hold cmd_valid until ready.
- Reset mid-command: immediate return to reset values, including all valves vented.

Test Plan (STEP_TICKS=2, WAIT_TICKS=3, SETTLE_TICKS=4):
- After reset, SET with arg={p=5'b10000, s=4'b0101, c=13'h1ABC} → on the accept edge c=1ABC, s=5, p=10000. busy for 4 cycles, then done=1 for 1 cycle with cmd_ready=1.
- After that SET, PUMP fwd with count=1 → p[2:0] sequence 001,001,011,011,010,010,110,110,100,100,101,101 (12 cycles), p[4:3]=10 throughout. Then p[2:0]=000 and done pulses.
- PUMP rev with count=2 → patterns 101,100,110,010,011,001 repeated twice, 24 busy cycles, then done.
- WAIT count=3 → 9 busy cycles, outputs constant, done. WAIT count=0 → 1 busy cycle, then done.
- PUMP fwd count=5, abort asserted in the 7th busy cycle → next cycle IDLE, p[2:0]=p_hold, aborted=1, done=0.
- op=3 → err=1, cmd_ready stays 1, no done. A subsequent SET executes normally and err remains 1. Asserting rst mid-PUMP → all outputs 0 immediately.
